// File: rtl/drv_led.sv
// LED blink driver: each event strobe becomes one fixed-length blink (ON_CYC lit, OFF_CYC dark).
// Events arriving during a blink are queued in a saturating counter and replayed back-to-back.
module drv_led #(
   parameter int unsigned ON_CYC   = 4,
   parameter int unsigned OFF_CYC  = 3,
   parameter int unsigned MAX_PEND = 3,
   parameter int unsigned PEND_W   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              evt_i,
   output logic              led_o,
   output logic              busy_o,
   output logic [PEND_W-1:0] pend_o,
   output logic              drop_o
);

   localparam int unsigned T_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF
   } state_t;

   state_t             r_state;
   logic [TMR_W-1:0]   r_tmr;
   logic [PEND_W-1:0]  r_pend;
   logic               r_led;
   logic               r_busy;
   logic               r_drop;

   logic w_off_end;
   logic w_start_q;
   logic w_evt_used;
   logic w_inc;
   logic w_drop;

   // A queued event takes priority at OFF end; a fresh event is only consumed directly if the queue is empty.
   assign w_off_end  = (r_state == S_OFF) && (r_tmr == '0);
   assign w_start_q  = w_off_end && (r_pend != '0);
   assign w_evt_used = evt_i && ((r_state == S_IDLE) || (w_off_end && (r_pend == '0)));
   assign w_inc      = evt_i && !w_evt_used;
   assign w_drop     = w_inc && !w_start_q && (r_pend == PEND_W'(MAX_PEND));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_pend  <= '0;
         r_led   <= 1'b0;
         r_busy  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_drop <= w_drop;

         if (w_inc && !w_start_q && !w_drop) begin
            r_pend <= r_pend + PEND_W'(1);
         end else if (w_start_q && !w_inc) begin
            r_pend <= r_pend - PEND_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (evt_i) begin
                  r_state <= S_ON;
                  r_tmr   <= TMR_W'(ON_CYC - 1);
                  r_led   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_ON: begin
               if (r_tmr == '0) begin
                  r_state <= S_OFF;
                  r_tmr   <= TMR_W'(OFF_CYC - 1);
                  r_led   <= 1'b0;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            S_OFF: begin
               if (r_tmr == '0) begin
                  if ((r_pend != '0) || evt_i) begin
                     r_state <= S_ON;
                     r_tmr   <= TMR_W'(ON_CYC - 1);
                     r_led   <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tmr   <= '0;
               r_led   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign led_o  = r_led;
   assign busy_o = r_busy;
   assign pend_o = r_pend;
   assign drop_o = r_drop;

endmodule

// File: tb/tb_drv_led.sv
// Scoreboard bench for drv_led: a blink-position model pushes expected outputs per cycle,
// compared one edge later; scenario totals (blinks, drops, busy fall) checked against fixed values.
module tb_drv_led;

   localparam int ON   = 4;
   localparam int OFF  = 3;
   localparam int MAXP = 3;
   localparam int PW   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          evt;
   logic          led;
   logic          busy;
   logic [PW-1:0] pend;
   logic          drop;

   always #5 clk = ~clk;

   drv_led #(
      .ON_CYC  (ON),
      .OFF_CYC (OFF),
      .MAX_PEND(MAXP),
      .PEND_W  (PW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .evt_i (evt),
      .led_o (led),
      .busy_o(busy),
      .pend_o(pend),
      .drop_o(drop)
   );

   typedef struct {
      int led;
      int busy;
      int pend;
      int drop;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // model: active flag plus position inside the ON+OFF blink window
   int m_act  = 0;
   int m_pos  = 0;
   int m_pend = 0;
   int m_drop = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic e, input logic r);
      if (r) begin
         m_act = 0; m_pos = 0; m_pend = 0; m_drop = 0;
      end else begin
         m_drop = 0;
         if (m_act == 0) begin
            if (e) begin
               m_act = 1; m_pos = 0;
            end
         end else if (m_pos == ON + OFF - 1) begin
            if (m_pend > 0) begin
               m_pos = 0;
               if (!e) m_pend--;
            end else if (e) begin
               m_pos = 0;
            end else begin
               m_act = 0;
            end
         end else begin
            m_pos++;
            if (e) begin
               if (m_pend < MAXP) m_pend++;
               else m_drop = 1;
            end
         end
      end
   endtask

   task automatic run_scn(input string name, input logic [63:0] em, input logic [63:0] rm,
                          input int ncyc, output int nblink, output int ndrop, output int lastfall);
      exp_t x;
      logic pl;
      logic pb;
      nblink = 0; ndrop = 0; lastfall = 0;
      pl = 1'b0; pb = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         rst = rm[c];
         evt = em[c];
         model_step(evt, rst);
         x.led  = (m_act != 0 && m_pos < ON) ? 1 : 0;
         x.busy = m_act;
         x.pend = m_pend;
         x.drop = m_drop;
         sb.push_back(x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         chk($sformatf("%s.led@%0d", name, c + 1), int'(led), x.led);
         chk($sformatf("%s.busy@%0d", name, c + 1), int'(busy), x.busy);
         chk($sformatf("%s.pend@%0d", name, c + 1), int'(pend), x.pend);
         chk($sformatf("%s.drop@%0d", name, c + 1), int'(drop), x.drop);
         if (led && !pl) nblink++;
         if (drop) ndrop++;
         if (!busy && pb) lastfall = c + 1;
         pl = led;
         pb = busy;
      end
   endtask

   initial begin
      int nb;
      int nd;
      int lf;
      logic [63:0] em;
      rst = 1'b1;
      evt = 1'b0;

      run_scn("reset", 64'h7, 64'h7, 30, nb, nd, lf);
      chk("reset.blinks", nb, 0);

      run_scn("single", 64'h1 << 10, 64'h7, 40, nb, nd, lf);
      chk("single.blinks", nb, 1);
      chk("single.busyfall", lf, 18);

      run_scn("burst", 64'h7 << 10, 64'h7, 50, nb, nd, lf);
      chk("burst.blinks", nb, 3);
      chk("burst.busyfall", lf, 32);

      run_scn("ovf", 64'h1F << 10, 64'h7, 60, nb, nd, lf);
      chk("ovf.blinks", nb, 4);
      chk("ovf.drops", nd, 1);
      chk("ovf.busyfall", lf, 39);

      run_scn("coinc", (64'h1 << 10) | (64'h1 << 17), 64'h7, 40, nb, nd, lf);
      chk("coinc.blinks", nb, 2);
      chk("coinc.busyfall", lf, 25);

      run_scn("rstmid", 64'h3 << 10, 64'h7 | (64'h1 << 12), 40, nb, nd, lf);
      chk("rstmid.blinks", nb, 1);
      chk("rstmid.busyfall", lf, 13);

      for (int k = 0; k < 4; k++) begin
         em = {$urandom, $urandom} & {$urandom, $urandom};
         em[2:0] = 3'b101;
         run_scn($sformatf("rnd%0d", k), em, 64'h7, 64, nb, nd, lf);
      end

      chk("sb.empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
